adder_result_sink: RTL and testbench
====================================

# adder_result_sink

Receive end of the half-adder output stream: captures every `data_out`/`out_valid` beat into a small FIFO and forwards it downstream over a valid/ready handshake. Keeps a saturating running total of accepted sums and counts beats lost to overflow. The adder has no backpressure, so this block is the elastic point between the adder and any stalling consumer.

## Interface
Parameters:
- `DATA_W`, 10: sum width; matches the adder `data_out`.
- `DEPTH`, 4: FIFO entries; must be a power of two and ≥ 2.
- `ACC_W`, 16: running-total width.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sum_in`, input, DATA_W: connects to adder `data_out`.
- `sum_valid`, input, 1: connects to adder `out_valid`. There is no ready back to the adder.
- `m_data`, output, DATA_W: head-of-FIFO sum.
- `m_valid`, output, 1: FIFO non-empty.
- `m_ready`, input, 1: downstream accepts `m_data` when `m_valid && m_ready`.
- `clr`, input, 1: synchronous clear of `acc`, `acc_sat` and `drop_cnt`. FIFO contents are untouched.
- `level`, output, $clog2(DEPTH+1): current FIFO occupancy.
- `acc`, output, ACC_W: saturating sum of all accepted beats.
- `acc_sat`, output, 1: sticky; set when `acc` saturates.
- `drop`, output, 1: one-cycle pulse when a beat is discarded.
- `drop_cnt`, output, 8: saturating count of discarded beats.

## Operation
- Push when `sum_valid` is high. A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- When `sum_valid` is high and the FIFO is full with no pop:
  - the beat is discarded and FIFO contents are unchanged;
  - `drop` pulses;
  - `drop_cnt` increments, saturating at 255.
- Pop when `m_valid && m_ready`. `m_ready` while empty is a no-op.
- Simultaneous push and pop: `level` is unchanged. Valid at every level, including empty and full. When empty, the pushed beat appears on `m_data` the next cycle.
- Pointers are log2(DEPTH)+1 bits. Wrap-around is natural modulo 2·DEPTH.
  - full = MSBs differ and LSBs are equal.
  - empty = pointers equal.
- Accumulator:
  - On each accepted push, `acc` ← min(`acc` + `sum_in`, 2^ACC_W−1), with `sum_in` zero-extended.
  - `acc_sat` is set in the same cycle that the clamp applies.
  - Dropped beats do not accumulate.
- `clr`:
  - `acc` ← 0, `acc_sat` ← 0, `drop_cnt` ← 0.
  - If an accepted push coincides with `clr`, `acc` ← `sum_in`.
  - If a drop coincides with `clr`, `drop_cnt` ← 1.
  - `clr` does not affect `drop`, the FIFO or `m_*`.
- Reset (asynchronous, any cycle, including mid-burst): FIFO emptied, pointers ← 0, all outputs ← 0. Any in-flight beat is lost and is not counted as a drop.

## Timing
- Write latency: a beat pushed in cycle N is visible on `m_data`/`m_valid` in cycle N+1 (registered first-word fall-through).
- `m_data` is stable while `m_valid && !m_ready`.
- After a pop in cycle N, the next entry is presented in N+1 with no bubble.
- `level`, `acc`, `acc_sat` and `drop_cnt` update in the cycle after the causing event.
- `drop` is asserted in cycle N+1 for a discard in cycle N.
- The adder presents back-to-back beats every cycle. Sustained throughput of 1 beat/cycle is required whenever `m_ready` is held high.

## Structure
- Shared package `adder_pkg` holds:
  - `SUM_W` = 10, the default for `DATA_W`;
  - `typedef logic [SUM_W-1:0] sum_t`;
  - `ACC_W_DEFAULT` = 16;
  - `DROP_CNT_W` = 8.
  The adder bench reuses the same package.
- Sub-module `sync_fifo` (parameters DATA_W and DEPTH; push/pop/full/empty/level) holds storage and pointers.
- The top level holds push qualification, the accumulator, the drop logic and `clr` handling.

## Test plan
- Single beat: `sum_in`=0x1FF, `sum_valid` for one cycle, `m_ready`=1 → `m_data`=0x1FF and `m_valid`=1 in the next cycle only; then `acc`=511 and `level` returns to 0.
- Fill and overflow: `m_ready`=0, 6 beats of values 1..6 → `level`=4; `drop` pulses twice; `drop_cnt`=2; `acc`=10; draining yields 1, 2, 3, 4 in order.
- Full with push and pop in the same cycle: FIFO full, `sum_valid` with value 9 plus `m_ready`=1 → `level` stays 4, no drop, 9 exits last.
- Saturation: 129 beats of 0x1FF, `m_ready`=1 → `acc`=65535 and `acc_sat`=1. Then `clr` together with a push of 5 → `acc`=5, `acc_sat`=0.
- Reset mid-burst: `rst_n` low while `level`=3 → same-cycle `m_valid`=0, `level`=0, `acc`=0, `drop_cnt`=0. After release, the first beat passes with 1-cycle latency.
- Streaming: 100 random beats on consecutive cycles, random `m_ready` at 50% → scoreboard order matches; `acc` equals the sum of non-dropped beats; drops occur only when `level`=4.

Source files
------------

// File: rtl/adder_pkg.sv
// Types and widths shared by the half-adder and its result sink.
package adder_pkg;
  localparam int SUM_W         = 10;
  localparam int ACC_W_DEFAULT = 16;
  localparam int DROP_CNT_W    = 8;

  typedef logic [SUM_W-1:0] sum_t;
endpackage

// File: rtl/sync_fifo.sv
// Registered first-word fall-through FIFO with extra-MSB pointers.
module sync_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     diff;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign diff  = wr_ptr - rd_ptr;
  assign level = LW'(diff);
  // Empty reads return zero so the output bus is clean out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/adder_result_sink.sv
// Elastic receive point for the adder stream: FIFO, saturating total, drop accounting.
module adder_result_sink
  import adder_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = ACC_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          sum_in,
  input  logic                       sum_valid,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       clr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [ACC_W-1:0]           acc,
  output logic                       acc_sat,
  output logic                       drop,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);
  localparam int AW1 = ACC_W + 1;

  logic full_p0;
  logic empty_p0;
  logic pop_p0;
  logic push_p0;
  logic drop_p0;
  logic [AW1-1:0] acc_sum_p0;

  // Returns {clamped, value}.
  function automatic logic [AW1-1:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [AW1-1:0] s;
    s = {1'b0, a} + AW1'(b);
    if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_p0),
    .wdata (sum_in),
    .pop   (pop_p0),
    .rdata (m_data),
    .full  (full_p0),
    .empty (empty_p0),
    .level (level)
  );

  // Stage p0: qualify the incoming beat against FIFO state and this cycle's pop.
  assign m_valid    = !empty_p0;
  assign pop_p0     = m_valid && m_ready;
  assign push_p0    = sum_valid && (!full_p0 || pop_p0);
  assign drop_p0    = sum_valid && full_p0 && !pop_p0;
  assign acc_sum_p0 = sat_add(acc, sum_in);

  // Stage p1: registered statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      acc_sat  <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop <= drop_p0;
      if (clr) begin
        acc      <= push_p0 ? ACC_W'(sum_in) : '0;
        acc_sat  <= 1'b0;
        drop_cnt <= drop_p0 ? DROP_CNT_W'(1) : '0;
      end else begin
        if (push_p0) begin
          acc     <= acc_sum_p0[ACC_W-1:0];
          acc_sat <= acc_sat | acc_sum_p0[ACC_W];
        end
        if (drop_p0) drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end
endmodule

// File: tb/tb_adder_result_sink.sv
// Directed bench for adder_result_sink with a queue model for the streaming phase.
module tb_adder_result_sink;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sum_in;
  logic       sum_valid;
  logic [9:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       clr;
  logic [2:0] level;
  logic [15:0] acc;
  logic       acc_sat;
  logic       drop;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  adder_result_sink dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .clr       (clr),
    .level     (level),
    .acc       (acc),
    .acc_sat   (acc_sat),
    .drop      (drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] q[$];
    logic [15:0] m_acc;
    logic [7:0]  m_drops;
    logic [9:0]  d;
    logic        r;
    logic        p;
    logic        f;
    logic [16:0] s;
    logic [9:0]  exp4 [4];

    rst_n = 1'b0; sum_in = '0; sum_valid = 1'b0; m_ready = 1'b0; clr = 1'b0;
    step(); step();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_acc_sat", 32'(acc_sat), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    step();

    // Single beat
    sum_in = 10'h1FF; sum_valid = 1'b1; m_ready = 1'b1;
    step();
    sum_valid = 1'b0;
    check("single_m_valid", 32'(m_valid), 1);
    check("single_m_data", 32'(m_data), 32'h1FF);
    check("single_level", 32'(level), 1);
    check("single_acc", 32'(acc), 511);
    step();
    check("single_m_valid_gone", 32'(m_valid), 0);
    check("single_level_zero", 32'(level), 0);

    // Fill and overflow
    clr = 1'b1; m_ready = 1'b0;
    step();
    clr = 1'b0;
    check("clr_acc", 32'(acc), 0);
    for (int i = 1; i <= 6; i++) begin
      sum_in = 10'(i); sum_valid = 1'b1;
      step();
      check("fill_level", 32'(level), (i < 4) ? i : 4);
      check("fill_drop", 32'(drop), (i >= 5) ? 1 : 0);
    end
    sum_valid = 1'b0;
    check("fill_drop_cnt", 32'(drop_cnt), 2);
    check("fill_acc", 32'(acc), 10);
    check("fill_head", 32'(m_data), 1);

    // Full with simultaneous push and pop
    sum_in = 10'd9; sum_valid = 1'b1; m_ready = 1'b1;
    step();
    sum_valid = 1'b0;
    check("pp_level", 32'(level), 4);
    check("pp_drop", 32'(drop), 0);
    check("pp_drop_cnt", 32'(drop_cnt), 2);
    check("pp_acc", 32'(acc), 19);
    exp4[0] = 10'd2; exp4[1] = 10'd3; exp4[2] = 10'd4; exp4[3] = 10'd9;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(m_valid), 1);
      check("drain_data", 32'(m_data), 32'(exp4[i]));
      step();
    end
    check("drain_empty", 32'(m_valid), 0);
    check("drain_level", 32'(level), 0);

    // Saturation at 1 beat/cycle
    sum_in = 10'h1FF; sum_valid = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 129; i++) begin
      step();
      if (i == 127) begin
        check("sat_pre_acc", 32'(acc), 64916);
        check("sat_pre_flag", 32'(acc_sat), 0);
      end
    end
    check("sat_acc", 32'(acc), 65535);
    check("sat_flag", 32'(acc_sat), 1);
    check("sat_level_stream", 32'(level), 1);
    clr = 1'b1; sum_in = 10'd5;
    step();
    clr = 1'b0; sum_valid = 1'b0;
    check("clrpush_acc", 32'(acc), 5);
    check("clrpush_sat", 32'(acc_sat), 0);
    check("clrpush_data", 32'(m_data), 5);
    step();
    check("clrpush_drained", 32'(level), 0);

    // Drop coinciding with clr
    m_ready = 1'b0; sum_in = 10'd1; sum_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("clrdrop_full", 32'(level), 4);
    check("clrdrop_acc_pre", 32'(acc), 9);
    sum_in = 10'd7; clr = 1'b1;
    step();
    clr = 1'b0; sum_valid = 1'b0;
    check("clrdrop_cnt", 32'(drop_cnt), 1);
    check("clrdrop_acc", 32'(acc), 0);
    check("clrdrop_pulse", 32'(drop), 1);
    check("clrdrop_level", 32'(level), 4);

    // Reset mid-burst
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("mid_level3", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 0);
    check("arst_level", 32'(level), 0);
    check("arst_acc", 32'(acc), 0);
    check("arst_drop_cnt", 32'(drop_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    sum_in = 10'h2A; sum_valid = 1'b1;
    step();
    sum_valid = 1'b0; m_ready = 1'b1;
    check("post_rst_valid", 32'(m_valid), 1);
    check("post_rst_data", 32'(m_data), 32'h2A);
    step();
    check("post_rst_empty", 32'(m_valid), 0);

    // Streaming against a queue model
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_acc = '0; m_drops = '0;
    for (int i = 0; i < 100; i++) begin
      d = 10'($urandom_range(0, 1023));
      r = 1'($urandom_range(0, 1));
      sum_in = d; sum_valid = 1'b1; m_ready = r;
      check("strm_level", 32'(level), 32'(q.size()));
      check("strm_valid", 32'(m_valid), (q.size() != 0) ? 1 : 0);
      p = (q.size() != 0) && r;
      f = (q.size() == 4);
      if (p) begin
        check("strm_data", 32'(m_data), 32'(q[0]));
        void'(q.pop_front());
      end
      if (!f || p) begin
        q.push_back(d);
        s = {1'b0, m_acc} + 17'(d);
        m_acc = s[16] ? 16'hFFFF : s[15:0];
      end else if (m_drops != 8'hFF) begin
        m_drops = m_drops + 1'b1;
      end
      step();
      check("strm_drop", 32'(drop), (f && !p) ? 1 : 0);
    end
    sum_valid = 1'b0; m_ready = 1'b1;
    check("strm_acc", 32'(acc), 32'(m_acc));
    check("strm_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    while (q.size() != 0) begin
      check("strm_tail_data", 32'(m_data), 32'(q[0]));
      void'(q.pop_front());
      step();
    end
    check("strm_final_empty", 32'(m_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
